// File: rtl/head_ptr_table.sv
// Bucket-head table: one {ptr_val, data_ptr} entry per hash bucket, fixed-latency reads with write-first forwarding, full-table clear sweep.
// Optional HEAD_TABLE_STATS_EN adds saturating read/write counters rd_cnt_o / wr_cnt_o.
module head_ptr_table #(
   parameter int unsigned BUCKET_WIDTH = 8,
   parameter int unsigned PTR_WIDTH    = 10,
   parameter int unsigned RD_LATENCY   = 2
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic [BUCKET_WIDTH-1:0] rd_bucket_i,
   input  logic                    rd_en_i,
   output logic [PTR_WIDTH-1:0]    rd_data_ptr_o,
   output logic                    rd_data_ptr_val_o,
   output logic                    rd_valid_o,
   input  logic [BUCKET_WIDTH-1:0] wr_bucket_i,
   input  logic [PTR_WIDTH-1:0]    wr_data_ptr_i,
   input  logic                    wr_data_ptr_val_i,
   input  logic                    wr_en_i,
   input  logic                    clear_ram_run_i,
   output logic                    clear_ram_done_o,
   output logic                    ready_o
`ifdef HEAD_TABLE_STATS_EN
   ,
   output logic [31:0]             rd_cnt_o,
   output logic [31:0]             wr_cnt_o
`endif
);

   localparam int unsigned DEPTH = 2**BUCKET_WIDTH;

   typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;

   state_t                state, state_next;
   logic [BUCKET_WIDTH:0] cnt, cnt_inc;
   logic                  ready;
   logic                  idle;
   logic                  wr_accept;
   logic [PTR_WIDTH:0]    wr_entry;
   logic [PTR_WIDTH:0]    rd_entry;
   logic [PTR_WIDTH:0]    table_mem [DEPTH];
   logic                  s1_valid;
   logic [PTR_WIDTH:0]    s1_data;
   logic                  rsp_valid;
   logic [PTR_WIDTH:0]    rsp_data;

   assign idle      = (state == IDLE);
   assign wr_accept = wr_en_i && idle;
   assign wr_entry  = {wr_data_ptr_val_i, wr_data_ptr_i};

   always_comb begin
      state_next = state;
      cnt_inc    = cnt + 1'b1;
      case (state)
         IDLE:    if (clear_ram_run_i) state_next = CLEAR;
         // Counter MSB ends the sweep, so the index never wraps back to bucket 0
         CLEAR:   if (cnt_inc[BUCKET_WIDTH]) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // ready is registered so it reads 0 while reset is held, matching the other outputs
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state <= IDLE;
         cnt   <= '0;
         ready <= 1'b0;
      end else begin
         state <= state_next;
         ready <= (state_next == IDLE);
         cnt   <= (state == CLEAR) ? cnt_inc : '0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (state == CLEAR)
         table_mem[cnt[BUCKET_WIDTH-1:0]] <= '0;
      else if (wr_accept)
         table_mem[wr_bucket_i] <= wr_entry;
   end

   // Same-cycle write to the read bucket is forwarded; reads outside IDLE return an empty entry
   always_comb begin
      rd_entry = '0;
      if (idle) begin
         if (wr_accept && (wr_bucket_i == rd_bucket_i))
            rd_entry = wr_entry;
         else
            rd_entry = table_mem[rd_bucket_i];
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         s1_valid <= 1'b0;
         s1_data  <= '0;
      end else begin
         s1_valid <= rd_en_i;
         s1_data  <= rd_en_i ? rd_entry : '0;
      end
   end

   generate
      if (RD_LATENCY == 1) begin : g_lat1
         assign rsp_valid = s1_valid;
         assign rsp_data  = s1_data;
      end else begin : g_lat2
         logic               s2_valid;
         logic [PTR_WIDTH:0] s2_data;
         always_ff @(posedge clk_i or negedge rst_i) begin
            if (!rst_i) begin
               s2_valid <= 1'b0;
               s2_data  <= '0;
            end else begin
               s2_valid <= s1_valid;
               s2_data  <= s1_data;
            end
         end
         assign rsp_valid = s2_valid;
         assign rsp_data  = s2_data;
      end
   endgenerate

   assign rd_valid_o        = rsp_valid;
   assign rd_data_ptr_o     = rsp_data[PTR_WIDTH-1:0];
   assign rd_data_ptr_val_o = rsp_data[PTR_WIDTH];
   assign clear_ram_done_o  = (state == DONE);
   assign ready_o           = ready;

`ifdef HEAD_TABLE_STATS_EN
   logic [31:0] rd_cnt, wr_cnt;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         rd_cnt <= '0;
         wr_cnt <= '0;
      end else if (idle && clear_ram_run_i) begin
         rd_cnt <= '0;
         wr_cnt <= '0;
      end else begin
         if (idle && rd_en_i && (rd_cnt != '1)) rd_cnt <= rd_cnt + 32'd1;
         if (wr_accept && (wr_cnt != '1))       wr_cnt <= wr_cnt + 32'd1;
      end
   end

   assign rd_cnt_o = rd_cnt;
   assign wr_cnt_o = wr_cnt;
`endif

endmodule

// File: tb/tb_head_ptr_table.sv
// Self-checking bench for head_ptr_table (BUCKET_WIDTH=4): directed vector table, sweep/reset sequences, randomized traffic vs a table model.
module tb_head_ptr_table;

   localparam int unsigned BW    = 4;
   localparam int unsigned PW    = 10;
   localparam int          DEPTH = 16;

   logic          clk = 1'b0;
   logic          rst_i;
   logic [BW-1:0] rd_bucket_i;
   logic          rd_en_i;
   logic [PW-1:0] rd_data_ptr_o;
   logic          rd_data_ptr_val_o;
   logic          rd_valid_o;
   logic [BW-1:0] wr_bucket_i;
   logic [PW-1:0] wr_data_ptr_i;
   logic          wr_data_ptr_val_i;
   logic          wr_en_i;
   logic          clear_ram_run_i;
   logic          clear_ram_done_o;
   logic          ready_o;

   head_ptr_table #(.BUCKET_WIDTH(BW), .PTR_WIDTH(PW), .RD_LATENCY(2)) dut (
      .clk_i(clk), .rst_i(rst_i),
      .rd_bucket_i(rd_bucket_i), .rd_en_i(rd_en_i),
      .rd_data_ptr_o(rd_data_ptr_o), .rd_data_ptr_val_o(rd_data_ptr_val_o), .rd_valid_o(rd_valid_o),
      .wr_bucket_i(wr_bucket_i), .wr_data_ptr_i(wr_data_ptr_i),
      .wr_data_ptr_val_i(wr_data_ptr_val_i), .wr_en_i(wr_en_i),
      .clear_ram_run_i(clear_ram_run_i), .clear_ram_done_o(clear_ram_done_o), .ready_o(ready_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          due;
      logic [PW:0] data;
      bit          known;
   } rsp_t;

   typedef struct {
      logic          rd_en;
      logic [BW-1:0] rd_b;
      logic          wr_en;
      logic [BW-1:0] wr_b;
      logic [PW-1:0] wr_p;
      logic          wr_v;
      logic          exp_valid;
      logic [PW-1:0] exp_ptr;
      logic          exp_val;
   } vec_t;

   int          n_vec = 0;
   int          n_bad = 0;
   int          cyc = 0;
   bit          sweep_on = 1'b0;
   int          sweep_b = 0;
   logic [PW:0] mdl [DEPTH];
   bit          mknown [DEPTH];
   rsp_t        q [$];
   vec_t        vt [12];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp);
      end
   endtask

   function automatic bit in_sweep(input int c);
      return sweep_on && (c >= sweep_b) && (c <= sweep_b + DEPTH);
   endfunction

   // One clock: drive inputs, advance the model, then check outputs of the next cycle
   task automatic tick(input logic re, input logic [BW-1:0] rb, input logic we, input logic [BW-1:0] wb,
                       input logic [PW-1:0] wp, input logic wv, input logic clr);
      bit   busy;
      rsp_t r;
      rd_en_i = re; rd_bucket_i = rb; wr_en_i = we; wr_bucket_i = wb;
      wr_data_ptr_i = wp; wr_data_ptr_val_i = wv; clear_ram_run_i = clr;
      busy = in_sweep(cyc);
      if (re) begin
         r.due = cyc + 2;
         if (busy) begin r.data = '0; r.known = 1'b1; end
         else if (we && wb == rb) begin r.data = {wv, wp}; r.known = 1'b1; end
         else begin r.data = mdl[rb]; r.known = mknown[rb]; end
         q.push_back(r);
      end
      if (we && !busy) begin mdl[wb] = {wv, wp}; mknown[wb] = 1'b1; end
      if (clr && !busy) begin
         sweep_on = 1'b1;
         sweep_b  = cyc + 1;
         for (int i = 0; i < DEPTH; i++) begin mdl[i] = '0; mknown[i] = 1'b1; end
      end
      @(posedge clk); #1;
      cyc++;
      chk("ready", 32'(ready_o), 32'(!in_sweep(cyc)));
      chk("done", 32'(clear_ram_done_o), 32'(sweep_on && cyc == sweep_b + DEPTH));
      if (q.size() > 0 && q[0].due == cyc) begin
         r = q.pop_front();
         chk("rd_valid", 32'(rd_valid_o), 32'd1);
         if (r.known) begin
            chk("rd_ptr", 32'(rd_data_ptr_o), 32'(r.data[PW-1:0]));
            chk("rd_val", 32'(rd_data_ptr_val_o), 32'(r.data[PW]));
         end
      end else begin
         chk("rd_valid", 32'(rd_valid_o), 32'd0);
      end
   endtask

   task automatic nop(input int n);
      for (int i = 0; i < n; i++) tick(1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b0);
   endtask

   task automatic do_reset();
      rd_en_i = 1'b0; wr_en_i = 1'b0; clear_ram_run_i = 1'b0;
      rst_i = 1'b0;
      #1;
      chk("rst_valid", 32'(rd_valid_o), 32'd0);
      chk("rst_ptr", 32'(rd_data_ptr_o), 32'd0);
      chk("rst_val", 32'(rd_data_ptr_val_o), 32'd0);
      chk("rst_done", 32'(clear_ram_done_o), 32'd0);
      chk("rst_ready", 32'(ready_o), 32'd0);
      q.delete();
      sweep_on = 1'b0;
      for (int i = 0; i < DEPTH; i++) mknown[i] = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      chk("rst_hold_done", 32'(clear_ram_done_o), 32'd0);
      rst_i = 1'b1;
   endtask

   initial begin
      int            low, done_at, c0;
      logic          re, we, wv, clr;
      logic [BW-1:0] rb, wb;
      logic [PW-1:0] wp;

      vt[0]  = '{1'b0, 4'd0, 1'b1, 4'd5, 10'h12A, 1'b1, 1'b0, 10'h000, 1'b0};
      vt[1]  = '{1'b1, 4'd5, 1'b0, 4'd0, 10'h000, 1'b0, 1'b0, 10'h000, 1'b0};
      vt[2]  = '{1'b0, 4'd0, 1'b0, 4'd0, 10'h000, 1'b0, 1'b1, 10'h12A, 1'b1};
      vt[3]  = '{1'b1, 4'd3, 1'b1, 4'd3, 10'h055, 1'b1, 1'b0, 10'h000, 1'b0};
      vt[4]  = '{1'b0, 4'd0, 1'b1, 4'd3, 10'h0AA, 1'b1, 1'b1, 10'h055, 1'b1};
      vt[5]  = '{1'b1, 4'd3, 1'b0, 4'd0, 10'h000, 1'b0, 1'b0, 10'h000, 1'b0};
      vt[6]  = '{1'b1, 4'd0, 1'b1, 4'd9, 10'h3FF, 1'b1, 1'b1, 10'h0AA, 1'b1};
      vt[7]  = '{1'b1, 4'd9, 1'b0, 4'd0, 10'h000, 1'b0, 1'b1, 10'h000, 1'b0};
      vt[8]  = '{1'b0, 4'd0, 1'b0, 4'd0, 10'h000, 1'b0, 1'b1, 10'h3FF, 1'b1};
      vt[9]  = '{1'b1, 4'd9, 1'b1, 4'd9, 10'h155, 1'b0, 1'b0, 10'h000, 1'b0};
      vt[10] = '{1'b0, 4'd0, 1'b0, 4'd0, 10'h000, 1'b0, 1'b1, 10'h155, 1'b0};
      vt[11] = '{1'b0, 4'd0, 1'b0, 4'd0, 10'h000, 1'b0, 1'b0, 10'h000, 1'b0};

      rst_i = 1'b0; rd_en_i = 1'b0; rd_bucket_i = '0; wr_en_i = 1'b0; wr_bucket_i = '0;
      wr_data_ptr_i = '0; wr_data_ptr_val_i = 1'b0; clear_ram_run_i = 1'b0;
      @(posedge clk); #1;
      do_reset();

      // Clear sweep timing: ready low 17 cycles, done 17 cycles after the request
      tick(1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b1);
      c0 = cyc - 1; low = 0; done_at = -1;
      for (int k = 0; k < 40; k++) begin
         if (!ready_o) low++;
         if (clear_ram_done_o) done_at = cyc - c0;
         nop(1);
      end
      chk("sweep_ready_low", 32'(low), 32'd17);
      chk("sweep_done_offset", 32'(done_at), 32'd17);
      for (int b = 0; b < DEPTH; b++) tick(1'b1, BW'(b), 1'b0, '0, '0, 1'b0, 1'b0);
      nop(2);

      for (int i = 0; i < 12; i++) begin
         tick(vt[i].rd_en, vt[i].rd_b, vt[i].wr_en, vt[i].wr_b, vt[i].wr_p, vt[i].wr_v, 1'b0);
         chk("vec_valid", 32'(rd_valid_o), 32'(vt[i].exp_valid));
         if (vt[i].exp_valid) begin
            chk("vec_ptr", 32'(rd_data_ptr_o), 32'(vt[i].exp_ptr));
            chk("vec_val", 32'(rd_data_ptr_val_o), 32'(vt[i].exp_val));
         end
      end

      // Write dropped during sweep, mid-sweep read returns empty entry, repeated request ignored
      tick(1'b0, '0, 1'b1, 4'd7, 10'h001, 1'b1, 1'b0);
      tick(1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b1);
      nop(3);
      tick(1'b1, 4'd7, 1'b1, 4'd7, 10'h003, 1'b1, 1'b1);
      tick(1'b1, 4'd4, 1'b0, '0, '0, 1'b0, 1'b0);
      nop(20);
      tick(1'b1, 4'd7, 1'b0, '0, '0, 1'b0, 1'b0);
      nop(2);

      // Reset while bucket 6 is being cleared, then a clean re-run
      tick(1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b1);
      for (int k = 0; k < 20 && cyc < sweep_b + 6; k++) nop(1);
      chk("reset_point", 32'(cyc - sweep_b), 32'd6);
      do_reset();
      nop(20);
      tick(1'b0, '0, 1'b1, 4'd2, 10'h2AB, 1'b1, 1'b1);
      nop(18);
      tick(1'b1, 4'd2, 1'b0, '0, '0, 1'b0, 1'b0);
      tick(1'b1, 4'd6, 1'b0, '0, '0, 1'b0, 1'b0);
      nop(2);

      for (int k = 0; k < 800; k++) begin
         re  = 1'($urandom_range(0, 1));
         we  = 1'($urandom_range(0, 1));
         rb  = $urandom_range(0, 1) ? BW'($urandom_range(0, 3)) : BW'($urandom_range(0, 15));
         wb  = $urandom_range(0, 1) ? BW'($urandom_range(0, 3)) : BW'($urandom_range(0, 15));
         wp  = PW'($urandom);
         wv  = 1'($urandom_range(0, 1));
         clr = ($urandom_range(0, 199) == 0);
         tick(re, rb, we, wb, wp, wv, clr);
      end
      nop(3);
      chk("queue_drained", 32'(q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
